// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store initiator: RV32I width codes, FSM states and
// the default memory depth.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned MEM_DEPTH_DEFAULT = 1024;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RESP
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane logic: extracts/extends a load from a memory word and merges a
// byte or halfword store into the previously read word.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    input  logic [15:0] wdata,
    output logic [31:0] ld_data,
    output logic [31:0] st_word
);

    function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] o,
                                                 input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(w >> {o, 3'b000});
        h = 16'(w >> {o[1], 4'b0000});
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_W:    r = w;
            F3_BU:   r = {24'h0, b};
            F3_HU:   r = {16'h0, h};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [15:0] wd,
                                                input logic [1:0] o, input logic [2:0] f3);
        logic [31:0] mask;
        logic [31:0] data;
        case (f3)
            F3_H: begin
                mask = 32'h0000_FFFF << {o[1], 4'b0000};
                data = {16'h0, wd} << {o[1], 4'b0000};
            end
            default: begin
                mask = 32'h0000_00FF << {o, 3'b000};
                data = {24'h0, wd[7:0]} << {o, 3'b000};
            end
        endcase
        return (old & ~mask) | (data & mask);
    endfunction

    assign ld_data = load_extract(word, off, funct3);
    assign st_word = store_merge(word, wdata, off, funct3);

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator driving a word memory with a combinational read
// port; sub-word stores use read-modify-write. Define LSU_MISALIGN_TRAP_EN to flag misaligned
// accesses as errors instead of aligning them down.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       mem_A,
    output logic [31:0]       mem_WD,
    output logic              mem_WE,
    input  logic [31:0]       mem_RD
);

    lsu_state_e        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_wd_q, mem_wd_d;

    logic              f3_legal, is_half, is_word, out_of_range, req_err;
    logic [ADDR_W-1:0] req_addr_eff;
    logic [31:0]       ld_data, st_word;

    // Request decode, evaluated against the live request pins in IDLE.
    always_comb begin
        f3_legal = 1'b0;
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = ~req_we;
            default:          f3_legal = 1'b0;
        endcase
        is_half      = (req_funct3 == F3_H) || (req_funct3 == F3_HU);
        is_word      = (req_funct3 == F3_W);
        out_of_range = (64'(req_addr) >> 2) >= 64'(MEM_DEPTH);
        req_addr_eff = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        req_err = ~f3_legal | out_of_range | (is_half & req_addr[0]) |
                  (is_word & (|req_addr[1:0]));
`else
        if (is_half) req_addr_eff[0] = 1'b0;
        if (is_word) req_addr_eff[1:0] = 2'b00;
        req_err = ~f3_legal | out_of_range;
`endif
    end

    lsu_lane_align u_lane_align (
        .word    (mem_RD),
        .off     (addr_q[1:0]),
        .funct3  (funct3_q),
        .wdata   (wdata_q),
        .ld_data (ld_data),
        .st_word (st_word)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        mem_we_d = 1'b0;
        mem_wd_d = mem_wd_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr_eff;
                    wdata_d  = req_wdata[15:0];
                    rdata_d  = 32'h0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (!req_we || req_funct3 != F3_W) begin
                        state_d = S_RD;
                    end else begin
                        state_d  = S_WR;
                        mem_we_d = 1'b1;
                        mem_wd_d = req_wdata;
                    end
                end
            end
            S_RD: begin
                // Stores only pass through RD when they are sub-word (read-modify-write).
                if (we_q) begin
                    state_d  = S_WR;
                    mem_we_d = 1'b1;
                    mem_wd_d = st_word;
                end else begin
                    state_d = S_RESP;
                    rdata_d = ld_data;
                end
            end
            S_WR: state_d = S_RESP;
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 16'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
            mem_we_q <= 1'b0;
            mem_wd_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            mem_we_q <= mem_we_d;
            mem_wd_q <= mem_wd_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_A     = 32'(addr_q >> 2);
    assign mem_WD    = mem_wd_q;
    assign mem_WE    = mem_we_q;

endmodule

// File: doc/lsu_mem_initiator.md
# lsu_mem_initiator

Load/store initiator sitting between the core's execute stage and the word-organised data memory. Accepts one load or store request at a time over a valid/ready handshake and drives the memory's address, write-data and write-enable pins. Uses the memory's combinational read path to return sign- or zero-extended loads. Performs read-modify-write for byte and halfword stores. Returns exactly one response per request over a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of requests.
- MEM_DEPTH, 1024, number of 32-bit words in the target memory; used only for the range check.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  misaligned access, out-of-range access, or illegal funct3.
- mem_A  out  32  word index, equal to req_addr[ADDR_W-1:2] zero-extended.
- mem_WD  out  32  write word.
- mem_WE  out  1  write enable, sampled by the memory on rising clk.
- mem_RD  in  32  combinational read word.

## Operation
- States:
  - IDLE: req_ready=1.
  - RD: sample mem_RD.
  - WR: mem_WE=1 for exactly one cycle.
  - RESP: rsp_valid=1.
- On handshake in IDLE, register we, funct3, addr and wdata; mem_A is driven from the registered address.
- Transitions:
  - Load: IDLE→RD→RESP.
  - SW: IDLE→WR→RESP.
  - SB/SH: IDLE→RD→WR→RESP. RD captures the old word; WR writes the merged word.
  - Error: IDLE→RESP with rsp_err=1. No memory access and mem_WE stays 0.
- Error conditions:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Out of range: word index ≥ MEM_DEPTH.
  - Illegal funct3, including 011, 110, 111, and 1xx on a store.
- Little-endian lanes:
  - Byte lane is addr[1:0].
  - Halfword lane is addr[1].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Merge: replace only the addressed lane with req_wdata[7:0] or req_wdata[15:0]; all other bytes keep the RD-captured value.
- RESP holds rsp_valid, rsp_rdata and rsp_err stable until rsp_ready=1, then returns to IDLE.
- No new request is accepted in that same cycle.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_WE=0, mem_A=0, mem_WD=0.
- rsp_valid rises this many cycles after the accepting edge:
  - Load: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- Throughput with rsp_ready tied to 1 is one request per 3 cycles (4 for SB/SH).
- mem_WE is a registered output, high only in WR.
- mem_WD is stable during the whole WR cycle.
- Reset asserted mid-operation:
  - mem_WE drops immediately.
  - A write not yet clocked is lost.
  - The pending response is discarded.
- The memory returns 0 on mem_RD while rst is low. The block never samples mem_RD in that window.
- req_valid while not in IDLE is ignored. req_* need not stay stable after acceptance.

## Configuration
- LSU_MISALIGN_TRAP_EN defined: misaligned accesses produce rsp_err=1 as above.
- LSU_MISALIGN_TRAP_EN undefined:
  - The low address bits below the access size are forced to 0 and the access proceeds normally.
  - rsp_err covers only out-of-range and illegal funct3.

## Structure
- lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - The state enum (S_IDLE, S_RD, S_WR, S_RESP).
  - The MEM_DEPTH default.
- Sub-module lsu_lane_align (purely combinational) holds the shared lane logic, with two functions:
  - Load extract and extend: (word, addr[1:0], funct3) → rdata.
  - Store merge: (old word, wdata, addr[1:0], funct3) → new word.
- The top module holds the FSM, the request registers and the memory-side drivers.

## Test plan
- Word round trip: SW addr 0x70 data 0xDEADBEEF, then LW 0x70 → mem_A=28, one mem_WE pulse, rsp_rdata=0xDEADBEEF, rsp_err=0.
- Load widths: preload word 40 with 0x8001F0A5.
  - LB at 0xA0 → 0xFFFFFFA5.
  - LBU at 0xA0 → 0x000000A5.
  - LH at 0xA2 → 0xFFFF8001.
  - LHU at 0xA2 → 0x00008001.
- Sub-word store RMW: word 7 = 0x11223344; SB addr 0x1D data 0xAB → word 7 = 0x1122AB44. This takes 3 cycles to rsp_valid, and mem_WE is high for exactly one cycle.
- Misaligned with LSU_MISALIGN_TRAP_EN defined: LW 0x72 → rsp_err=1 after 1 cycle, no mem_WE. Without the macro, the same request reads word 28.
- Backpressure: hold rsp_ready=0 for 5 cycles → rsp_valid and rsp_rdata stable, req_ready=0; release → IDLE on the next edge.
- Reset mid-store: assert rst during WR before the clock edge → mem_WE=0 immediately, memory word unchanged, outputs at reset values, req_ready=1 after release.
